axis_dac_sink: RTL and testbench
================================

Name: axis_dac_sink

Overview:
- AXI-Stream slave-end consumer for the DAC path: accepts sample packets on an IAxiStream-compatible slave port and buffers them in a synchronous FIFO.
- Plays samples out to the DAC register one per `sample_strobe` (rate enable from the timing generator).
- Filters by `tid`, counts frames on `tlast`, and flags underflow.
- Sits between the sample generator's AXIS master and the DAC output stage.

Parameters:
- DATA_SIZE, 32: tdata / dac_data width.
- ID_SIZE, 4: tid width.
- CHAN_ID, 0: tid value accepted into the FIFO; all other tid values are consumed and discarded.
- FIFO_DEPTH, 16: FIFO entries; power of 2, minimum 4.
- PREFILL, 4: FIFO level required before playout starts; range 1..FIFO_DEPTH.

Ports:
- aclk  in  1  single clock.
- areset  in  1  synchronous, active-high reset.
- s_axis_tvalid  in  1  slave valid.
- s_axis_tready  out  1  slave ready.
- s_axis_tlast  in  1  last word of frame.
- s_axis_tdata  in  DATA_SIZE  sample.
- s_axis_tid  in  ID_SIZE  channel id.
- enable  in  1  block enable; 0 forces IDLE and flushes the FIFO.
- sample_strobe  in  1  one-cycle playout request.
- clear_status  in  1  clears `underflow` and `drop_cnt`.
- dac_data  out  DATA_SIZE  registered output sample.
- dac_valid  out  1  one-cycle pulse when `dac_data` updates.
- dac_last  out  1  one-cycle pulse with `dac_valid` when the sample carried tlast.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- frame_cnt  out  16  frames played out; wraps.
- drop_cnt  out  16  words discarded for tid mismatch; saturates at 0xFFFF.
- underflow  out  1  sticky; set when a strobe finds the FIFO empty in RUN.

Behaviour:
- Reset, synchronous and active-high: all outputs 0, FIFO empty, state IDLE. Reset mid-transfer discards FIFO contents; tready is 0 during reset.
- Handshake: a word transfers when `s_axis_tvalid && s_axis_tready` on a rising `aclk`.
- `s_axis_tready = enable && !areset && (!full || s_axis_tid != CHAN_ID)`. It is combinational from the FIFO count and tid, and never depends on tvalid.
- Accepted words with `tid == CHAN_ID` push {tlast, tdata}. Mismatched words are consumed, and `drop_cnt` increments.
- FIFO:
  - Push is visible to a pop on the next cycle; no same-cycle bypass.
  - Simultaneous push and pop leaves the level unchanged.
- States:
  - IDLE: no pops. Strobes are ignored. `enable=1` -> FILL.
  - FILL: push only. Strobes are ignored, with no underflow. When `fifo_level >= PREFILL` -> RUN, evaluated on the registered level.
  - RUN: each strobe with FIFO non-empty pops one entry. The next cycle has `dac_data` = entry data, `dac_valid=1`, and `dac_last` = entry tlast. When `dac_last`, `frame_cnt` increments, wrapping 0xFFFF->0.
  - RUN, strobe with FIFO empty: `underflow` set, `dac_data` holds its previous value, `dac_valid=0`, state -> FILL.
  - Any state: `enable=0` -> IDLE in the next cycle. FIFO flushed, `fifo_level=0`. `dac_data` holds. Counters and `underflow` are retained.
- `clear_status` zeroes `underflow` and `drop_cnt` next cycle. If a set event occurs in the same cycle, the set event wins.
- Latency: strobe to `dac_valid` is 1 cycle. Accept to earliest playout is 2 cycles (push, then pop).

Decomposition:
- Package axis_dac_pkg contains:
  - state enum {IDLE, FILL, RUN}.
  - LEVEL_W localparam function.
  - packed entry struct {last, data}.
- Sub-module axis_sync_fifo:
  - Parameterised WIDTH and DEPTH; single clock; synchronous reset and flush.
  - Outputs: full, empty, level.

Test Plan:
- Reset: assert `areset` 3 cycles with tvalid=1 -> tready=0, all outputs 0, `fifo_level`=0.
- Prefill/playout (PREFILL=4): send 0x11..0x14, strobe every cycle from the start -> no `dac_valid` until level=4. Then `dac_data` = 0x11, 0x12, 0x13, 0x14, one cycle after each strobe.
- tid filter (CHAN_ID=2): send 6 words alternating tid 2/3 -> only tid-2 data is played out, `drop_cnt`=3. `clear_status` -> 0.
- Backpressure (DEPTH=16, no strobes, RUN blocked): master holds 20 words -> tready falls after 16 accepted, level=16. Words 17–20 are accepted after strobes free slots, with data order preserved.
- Underflow: 4 words in, 5 strobes -> 5th sets `underflow`=1, `dac_data` stays at the 4th value, state FILL. Sticky until `clear_status`.
- Frames/enable: 8-word frame with tlast on word 8 -> `dac_last` with sample 8, `frame_cnt`=1. Preload `frame_cnt` 0xFFFF -> wraps to 0. Drop `enable` mid-frame -> `fifo_level`=0 next cycle, and tready=0.

Source files
------------

// File: rtl/axis_dac_pkg.sv
// axis_dac_pkg: shared types for the DAC sink path.
//   state_e      : playout controller states (IDLE, FILL, RUN).
//   level_w()    : width of an occupancy count for a given FIFO depth.
//   dac_entry_t  : FIFO word, {last, data}.
package axis_dac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  // Occupancy needs one extra bit so that "full" (== depth) is representable.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Widest sample carried in a FIFO entry; the sink's DATA_SIZE must not exceed it.
  localparam int ENTRY_DATA_W = 32;

  typedef struct packed {
    logic                    last;
    logic [ENTRY_DATA_W-1:0] data;
  } dac_entry_t;

endpackage

// File: rtl/axis_dac_sink_fifo.sv
// axis_sync_fifo: single-clock synchronous FIFO with flush.
//   clk, rst      : clock and synchronous active-high reset.
//   flush         : empties the FIFO next cycle (overrides push/pop).
//   push, wdata   : write request and data (ignored when full).
//   pop, rdata    : read request (ignored when empty); rdata shows the head entry.
//   full, empty   : derived from the registered level.
//   level         : registered occupancy, 0..DEPTH.
module axis_sync_fifo
  import axis_dac_pkg::*;
#(
  parameter  int WIDTH = 33,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = level_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_ok_s, pop_ok_s, wr_en_s;

  assign full      = (level_q == LW'(DEPTH));
  assign empty     = (level_q == LW'(0));
  assign level     = level_q;
  assign rdata     = mem_q[rd_ptr_q];
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign wr_en_s   = push_ok_s && !flush;

  // Next pointer and level; flush returns everything to the empty state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = AW'(0);
      rd_ptr_d = AW'(0);
      level_d  = LW'(0);
    end else begin
      if (push_ok_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Pointer and level registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      level_q  <= LW'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/axis_dac_sink.sv
// axis_dac_sink: AXI-Stream consumer that buffers samples and plays them
// out to the DAC register one per sample_strobe.
//   aclk, areset        : clock, synchronous active-high reset.
//   s_axis_*            : AXI-Stream slave (tvalid/tready/tlast/tdata/tid).
//   enable              : 0 forces IDLE and flushes the FIFO.
//   sample_strobe       : one-cycle playout request.
//   clear_status        : clears underflow and drop_cnt (set events win).
//   dac_data/valid/last : registered playout sample, valid pulse, frame end.
//   fifo_level          : FIFO occupancy.
//   frame_cnt           : frames played out (wraps).
//   drop_cnt            : words discarded for tid mismatch (saturates).
//   underflow           : sticky, strobe found FIFO empty while running.
module axis_dac_sink
  import axis_dac_pkg::*;
#(
  parameter  int DATA_SIZE  = 32,
  parameter  int ID_SIZE    = 4,
  parameter  int CHAN_ID    = 0,
  parameter  int FIFO_DEPTH = 16,
  parameter  int PREFILL    = 4,
  localparam int LVL_W      = level_w(FIFO_DEPTH)
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic                 s_axis_tvalid,
  output logic                 s_axis_tready,
  input  logic                 s_axis_tlast,
  input  logic [DATA_SIZE-1:0] s_axis_tdata,
  input  logic [ID_SIZE-1:0]   s_axis_tid,
  input  logic                 enable,
  input  logic                 sample_strobe,
  input  logic                 clear_status,
  output logic [DATA_SIZE-1:0] dac_data,
  output logic                 dac_valid,
  output logic                 dac_last,
  output logic [LVL_W-1:0]     fifo_level,
  output logic [15:0]          frame_cnt,
  output logic [15:0]          drop_cnt,
  output logic                 underflow
);

  state_e               state_q, state_d;
  logic [DATA_SIZE-1:0] dac_data_q, dac_data_d;
  logic                 dac_valid_q, dac_valid_d;
  logic                 dac_last_q, dac_last_d;
  logic [15:0]          frame_cnt_q, frame_cnt_d;
  logic [15:0]          drop_cnt_q, drop_cnt_d;
  logic                 underflow_q, underflow_d;

  logic                 tid_match_s, hs_s, push_s, drop_s;
  logic                 strobe_run_s, pop_s, uflow_s;
  logic                 full_s, empty_s;
  logic [LVL_W-1:0]     level_s;
  dac_entry_t           push_entry_s, pop_entry_s;

  // Mismatched tids are always consumable, so a full FIFO only stalls our channel.
  assign tid_match_s   = (s_axis_tid == ID_SIZE'(CHAN_ID));
  assign s_axis_tready = enable && !areset && (!full_s || !tid_match_s);
  assign hs_s          = s_axis_tvalid && s_axis_tready;
  assign push_s        = hs_s && tid_match_s;
  assign drop_s        = hs_s && !tid_match_s;

  assign strobe_run_s  = enable && (state_q == ST_RUN) && sample_strobe;
  assign pop_s         = strobe_run_s && !empty_s;
  assign uflow_s       = strobe_run_s && empty_s;

  assign push_entry_s.last = s_axis_tlast;
  assign push_entry_s.data = ENTRY_DATA_W'(s_axis_tdata);

  axis_sync_fifo #(
    .WIDTH ($bits(dac_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (aclk),
    .rst   (areset),
    .flush (!enable),
    .push  (push_s),
    .wdata (push_entry_s),
    .pop   (pop_s),
    .rdata (pop_entry_s),
    .full  (full_s),
    .empty (empty_s),
    .level (level_s)
  );

  // Playout controller next state; prefill is judged on the registered level.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_FILL;
        ST_FILL: begin
          if (level_s >= LVL_W'(PREFILL)) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_FILL;
          end
        end
        ST_RUN: begin
          if (uflow_s) begin
            state_d = ST_FILL;
          end else begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output sample, frame counter and status next values.
  always_comb begin
    dac_data_d  = dac_data_q;
    dac_valid_d = pop_s;
    dac_last_d  = pop_s && pop_entry_s.last;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    underflow_d = underflow_q;

    if (pop_s) begin
      dac_data_d = DATA_SIZE'(pop_entry_s.data);
    end else begin
      dac_data_d = dac_data_q;
    end

    if (pop_s && pop_entry_s.last) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end

    // A drop in the same cycle as clear_status takes priority over the clear.
    if (drop_s) begin
      if (drop_cnt_q != 16'hFFFF) begin
        drop_cnt_d = drop_cnt_q + 16'd1;
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end else if (clear_status) begin
      drop_cnt_d = 16'd0;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end

    if (uflow_s) begin
      underflow_d = 1'b1;
    end else if (clear_status) begin
      underflow_d = 1'b0;
    end else begin
      underflow_d = underflow_q;
    end
  end

  // State and output registers.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      dac_data_q  <= DATA_SIZE'(0);
      dac_valid_q <= 1'b0;
      dac_last_q  <= 1'b0;
      frame_cnt_q <= 16'd0;
      drop_cnt_q  <= 16'd0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dac_data_q  <= dac_data_d;
      dac_valid_q <= dac_valid_d;
      dac_last_q  <= dac_last_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      underflow_q <= underflow_d;
    end
  end

  assign dac_data   = dac_data_q;
  assign dac_valid  = dac_valid_q;
  assign dac_last   = dac_last_q;
  assign fifo_level = level_s;
  assign frame_cnt  = frame_cnt_q;
  assign drop_cnt   = drop_cnt_q;
  assign underflow  = underflow_q;

endmodule

// File: tb/tb_axis_dac_sink.sv
// tb_axis_dac_sink: directed self-checking bench for axis_dac_sink
// (CHAN_ID=2, FIFO_DEPTH=16, PREFILL=4).
module tb_axis_dac_sink;

  logic        aclk = 1'b0;
  logic        areset;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [31:0] s_axis_tdata;
  logic [3:0]  s_axis_tid;
  logic        enable;
  logic        sample_strobe;
  logic        clear_status;
  logic [31:0] dac_data;
  logic        dac_valid;
  logic        dac_last;
  logic [4:0]  fifo_level;
  logic [15:0] frame_cnt;
  logic [15:0] drop_cnt;
  logic        underflow;

  int checks   = 0;
  int failures = 0;

  // tx entry: {tlast, tid, data}; expected playout entry: {last, data}
  logic [36:0] tx_q [$];
  logic [32:0] exp_q [$];
  logic        hs;

  axis_dac_sink #(
    .DATA_SIZE  (32),
    .ID_SIZE    (4),
    .CHAN_ID    (2),
    .FIFO_DEPTH (16),
    .PREFILL    (4)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tid    (s_axis_tid),
    .enable        (enable),
    .sample_strobe (sample_strobe),
    .clear_status  (clear_status),
    .dac_data      (dac_data),
    .dac_valid     (dac_valid),
    .dac_last      (dac_last),
    .fifo_level    (fifo_level),
    .frame_cnt     (frame_cnt),
    .drop_cnt      (drop_cnt),
    .underflow     (underflow)
  );

  always #5 aclk = ~aclk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: present tx head, optional strobe, then score any playout.
  task automatic cycle(input logic strobe);
    logic [32:0] e;
    if (tx_q.size() > 0) begin
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = tx_q[0][36];
      s_axis_tid    = tx_q[0][35:32];
      s_axis_tdata  = tx_q[0][31:0];
    end else begin
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
    end
    sample_strobe = strobe;
    @(negedge aclk);
    hs = s_axis_tvalid && s_axis_tready;
    @(posedge aclk);
    #1;
    if (hs) void'(tx_q.pop_front());
    if (dac_valid) begin
      if (exp_q.size() == 0) begin
        check_val("extra_valid", {31'd0, dac_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_val("play_data", dac_data, e[31:0]);
        check_val("play_last", {31'd0, dac_last}, {31'd0, e[32]});
      end
    end
  endtask

  task automatic send(input logic last, input logic [3:0] tid, input logic [31:0] data);
    tx_q.push_back({last, tid, data});
  endtask

  task automatic expect_out(input logic last, input logic [31:0] data);
    exp_q.push_back({last, data});
  endtask

  initial begin
    int first_valid;
    int n;
    areset        = 1'b1;
    enable        = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = 1'b0;
    s_axis_tid    = 4'd2;
    s_axis_tdata  = 32'hAA;
    sample_strobe = 1'b0;
    clear_status  = 1'b0;

    // Reset held 3 cycles with tvalid high
    for (int i = 0; i < 3; i++) begin
      @(posedge aclk);
      #1;
      check_val("rst_tready", {31'd0, s_axis_tready}, 32'd0);
    end
    check_val("rst_level", {27'd0, fifo_level}, 32'd0);
    check_val("rst_data", dac_data, 32'd0);
    check_val("rst_valid", {31'd0, dac_valid}, 32'd0);
    check_val("rst_last", {31'd0, dac_last}, 32'd0);
    check_val("rst_frames", {16'd0, frame_cnt}, 32'd0);
    check_val("rst_drops", {16'd0, drop_cnt}, 32'd0);
    check_val("rst_uflow", {31'd0, underflow}, 32'd0);
    areset = 1'b0;
    s_axis_tvalid = 1'b0;

    // Prefill: 4 words, strobe every cycle; first playout after 6th edge
    for (int i = 0; i < 4; i++) begin
      send(1'b0, 4'd2, 32'h11 + 32'(i));
      expect_out(1'b0, 32'h11 + 32'(i));
    end
    first_valid = 0;
    for (int i = 1; i <= 9; i++) begin
      cycle(1'b1);
      if (dac_valid && first_valid == 0) first_valid = i;
    end
    check_val("prefill_first", 32'(first_valid), 32'd6);
    check_val("prefill_drain", 32'(exp_q.size()), 32'd0);
    check_val("prefill_level", {27'd0, fifo_level}, 32'd0);
    check_val("prefill_uflow", {31'd0, underflow}, 32'd0);

    // tid filter: alternate tid 2/3, only tid 2 is played
    for (int i = 0; i < 6; i++) begin
      send(1'b0, (i % 2 == 0) ? 4'd2 : 4'd3, 32'h21 + 32'(i));
    end
    expect_out(1'b0, 32'h21);
    expect_out(1'b0, 32'h23);
    expect_out(1'b0, 32'h25);
    for (int i = 0; i < 6; i++) cycle(1'b0);
    check_val("tid_level", {27'd0, fifo_level}, 32'd3);
    check_val("tid_drops", {16'd0, drop_cnt}, 32'd3);
    for (int i = 0; i < 3; i++) cycle(1'b1);
    check_val("tid_drain", 32'(exp_q.size()), 32'd0);
    clear_status = 1'b1;
    cycle(1'b0);
    clear_status = 1'b0;
    check_val("tid_clear", {16'd0, drop_cnt}, 32'd0);

    // Backpressure: 20 words held, 16 accepted
    for (int i = 0; i < 20; i++) begin
      send(1'b0, 4'd2, 32'h31 + 32'(i));
      expect_out(1'b0, 32'h31 + 32'(i));
    end
    for (int i = 0; i < 20; i++) cycle(1'b0);
    check_val("bp_level", {27'd0, fifo_level}, 32'd16);
    check_val("bp_tready", {31'd0, s_axis_tready}, 32'd0);
    check_val("bp_pending", 32'(tx_q.size()), 32'd4);
    for (int i = 0; i < 20; i++) cycle(1'b1);
    check_val("bp_drain", 32'(exp_q.size()), 32'd0);
    check_val("bp_level0", {27'd0, fifo_level}, 32'd0);
    check_val("bp_uflow", {31'd0, underflow}, 32'd0);

    // Underflow: 4 words, 5 strobes
    for (int i = 0; i < 4; i++) begin
      send(1'b0, 4'd2, 32'h51 + 32'(i));
      expect_out(1'b0, 32'h51 + 32'(i));
    end
    for (int i = 0; i < 4; i++) cycle(1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1);
    check_val("uf_flag", {31'd0, underflow}, 32'd1);
    check_val("uf_valid", {31'd0, dac_valid}, 32'd0);
    check_val("uf_hold", dac_data, 32'h54);
    // now in FILL: strobes are ignored
    send(1'b0, 4'd2, 32'h61);
    cycle(1'b1);
    cycle(1'b1);
    check_val("fill_nopop", {31'd0, dac_valid}, 32'd0);
    check_val("fill_level", {27'd0, fifo_level}, 32'd1);
    check_val("uf_sticky", {31'd0, underflow}, 32'd1);
    clear_status = 1'b1;
    cycle(1'b0);
    clear_status = 1'b0;
    check_val("uf_clear", {31'd0, underflow}, 32'd0);
    enable = 1'b0;
    cycle(1'b0);
    check_val("flush_level", {27'd0, fifo_level}, 32'd0);
    enable = 1'b1;

    // 8-word frame, tlast on word 8
    for (int i = 0; i < 8; i++) begin
      send(i == 7, 4'd2, 32'h71 + 32'(i));
      expect_out(i == 7, 32'h71 + 32'(i));
    end
    for (int i = 0; i < 8; i++) cycle(1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b1);
    check_val("frame_drain", 32'(exp_q.size()), 32'd0);
    check_val("frame_cnt1", {16'd0, frame_cnt}, 32'd1);

    // Run frame_cnt up to 0xFFFF with single-word frames
    for (int i = 0; i < 65534; i++) begin
      send(1'b1, 4'd2, 32'h1000_0000 + 32'(i));
      expect_out(1'b1, 32'h1000_0000 + 32'(i));
    end
    n = 0;
    while ((tx_q.size() > 0 || exp_q.size() > 0) && n < 70000) begin
      cycle(fifo_level != 5'd0);
      n++;
    end
    check_val("stream_done", 32'(exp_q.size()), 32'd0);
    check_val("frame_ffff", {16'd0, frame_cnt}, 32'h0000_FFFF);
    send(1'b1, 4'd2, 32'hBEEF);
    expect_out(1'b1, 32'hBEEF);
    cycle(1'b0);
    cycle(1'b1);
    check_val("frame_wrap", {16'd0, frame_cnt}, 32'd0);
    check_val("wrap_last", {31'd0, dac_last}, 32'd1);

    // Underflow set and clear_status in the same cycle: set wins
    clear_status = 1'b1;
    cycle(1'b1);
    clear_status = 1'b0;
    check_val("uf_setwins", {31'd0, underflow}, 32'd1);
    check_val("uf2_hold", dac_data, 32'hBEEF);

    // Drop enable mid-frame
    for (int i = 0; i < 4; i++) send(1'b0, 4'd2, 32'h81 + 32'(i));
    for (int i = 0; i < 3; i++) cycle(1'b0);
    check_val("mid_level", {27'd0, fifo_level}, 32'd3);
    enable = 1'b0;
    cycle(1'b0);
    check_val("dis_level", {27'd0, fifo_level}, 32'd0);
    check_val("dis_tready", {31'd0, s_axis_tready}, 32'd0);
    check_val("dis_data", dac_data, 32'hBEEF);
    check_val("dis_uflow", {31'd0, underflow}, 32'd1);
    check_val("dis_frames", {16'd0, frame_cnt}, 32'd0);
    tx_q.delete();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
